// File: rtl/sram_pkg.sv
// Shared state encoding and limits for the SRAM access controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int SRAM_DATA_W     = 8;
  localparam int SRAM_ADDR_W     = 19;
  localparam int WAIT_STATES_MAX = 15;
  localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/sram_iobuf.sv
// Tristate pad wrapper for the SRAM data bus; drives io only while oe is high.
module sram_iobuf
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] io
);

  assign io  = oe ? dout : {DATA_W{1'bz}};
  assign din = io;

endmodule

// File: rtl/sram_access_ctrl.sv
// Handshaked asynchronous-SRAM controller: one transaction per request, programmable
// wait states, a recovery cycle after every access, and fully registered pin outputs.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              WE,
  output logic              CE,
  output logic              OE,
  inout  wire  [DATA_W-1:0] IO,
  output logic [ADDR_W-1:0] A
);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
    $error("sram_access_ctrl: WAIT_STATES must be in 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    op_we_q, op_we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    ce_n_q, ce_n_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    io_oe_q, io_oe_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0]       io_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      io_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      io_oe_q     <= io_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_we_d = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RECOVER;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin strobes are decoded from the next state so the flops present them in step with the FSM.
  always_comb begin
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    io_oe_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_d)
      ACCESS: begin
        ce_n_d  = 1'b0;
        we_n_d  = ~op_we_d;
        oe_n_d  = op_we_d;
        io_oe_d = op_we_d;
      end
      RECOVER: io_oe_d = op_we_d;
      default: ;
    endcase
    if (state_q == ACCESS && state_d == RECOVER && !op_we_q) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = io_din;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign CE        = ce_n_q;
  assign WE        = we_n_q;
  assign OE        = oe_n_q;
  assign A         = addr_q;

  sram_iobuf #(.DATA_W(DATA_W)) u_iobuf (
    .oe   (io_oe_q),
    .dout (wdata_q),
    .din  (io_din),
    .io   (IO)
  );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: two instances (WAIT_STATES 1 and 0) each run
// directed and random transactions against an SRAM pin model and a reference memory.
module tb_sram_access_ctrl;

  localparam int AW = 19;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 1 : 0;

    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we    = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    wire           req_ready, rsp_valid, WE, CE, OE;
    wire  [DW-1:0] rsp_rdata;
    wire  [DW-1:0] IO;
    wire  [AW-1:0] A;

    sram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .WE        (WE),
      .CE        (CE),
      .OE        (OE),
      .IO        (IO),
      .A         (A)
    );

    // Asynchronous SRAM pin model: drives on a read strobe, stores while WE is low.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    assign IO = (!CE && !OE && WE) ? sram[A] : {DW{1'bz}};
    always @(negedge clk) if (rst_n && !CE && !WE) sram[A] <= IO;

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] written [$];
    exp_t          exp_rsp [$];
    exp_t          exp_wr  [$];
    int            cyc = 0;
    int            last_acc = -100;
    bit            prev_hold = 1'b0;
    bit            done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string tag(input string s);
      return $sformatf("u%0d.%s", g, s);
    endfunction

    // Called on a falling edge; returns on the falling edge just after the accept edge.
    task automatic applyStimulus(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 input bit hold, input bit commit);
      int   waited = 0;
      exp_t e;
      req_valid = 1'b1;
      req_we    = is_wr;
      req_addr  = addr;
      req_wdata = data;
      while (!req_ready && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!req_ready) begin
        checkOutput(tag("accept_timeout"), 0, 1);
        req_valid = 1'b0;
        prev_hold = 1'b0;
        return;
      end
      if (prev_hold) checkOutput(tag("b2b_spacing"), cyc - last_acc, W + 3);
      e.addr = addr;
      e.data = data;
      e.due  = cyc + W + 2;
      if (is_wr) begin
        exp_wr.push_back(e);
        if (commit) begin
          ref_mem[addr] = data;
          written.push_back(addr);
        end
      end else begin
        e.data = ref_mem[addr];
        exp_rsp.push_back(e);
      end
      last_acc  = cyc;
      prev_hold = hold;
      @(negedge clk);
      if (!hold) begin
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end
    endtask

    initial begin : monitor
      exp_t cur_wr;
      exp_t e;
      bit   we_prev = 1'b1;
      int   we_low = 0;
      int   oe_low = 0;
      cur_wr.addr = '0;
      cur_wr.data = '0;
      cur_wr.due  = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          we_prev = 1'b1;
          we_low  = 0;
          oe_low  = 0;
          checkOutput(tag("rst_rsp_valid"), rsp_valid, 0);
        end else begin
          checkOutput(tag("strobe_excl"), {31'd0, (!OE && !WE) || (!OE && CE) || (!WE && CE)}, 0);
          if (!OE) begin
            oe_low++;
            if (exp_rsp.size() != 0) checkOutput(tag("rd_addr"), A, exp_rsp[0].addr);
          end
          if (!WE) begin
            if (we_prev) begin
              if (exp_wr.size() == 0) begin
                checkOutput(tag("unexpected_write"), 1, 0);
                cur_wr.addr = A;
                cur_wr.data = IO;
              end else begin
                cur_wr = exp_wr.pop_front();
              end
              we_low = 0;
            end
            we_low++;
            checkOutput(tag("wr_addr"), A, cur_wr.addr);
            checkOutput(tag("wr_data"), IO, cur_wr.data);
          end else if (!we_prev) begin
            checkOutput(tag("we_low_cycles"), we_low, W + 1);
            checkOutput(tag("wr_hold_data"), IO, cur_wr.data);
            checkOutput(tag("wr_hold_addr"), A, cur_wr.addr);
          end
          we_prev = WE;
          if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
              checkOutput(tag("unexpected_rsp"), 1, 0);
            end else begin
              e = exp_rsp.pop_front();
              checkOutput(tag("rsp_data"), rsp_rdata, e.data);
              checkOutput(tag("rsp_latency"), cyc, e.due);
              checkOutput(tag("rsp_addr_held"), A, e.addr);
              checkOutput(tag("oe_low_cycles"), oe_low, W + 1);
            end
            oe_low = 0;
          end else if (exp_rsp.size() != 0 && cyc > exp_rsp[0].due) begin
            checkOutput(tag("rsp_missing"), 0, 1);
            void'(exp_rsp.pop_front());
          end
        end
      end
    end

    initial begin : stim
      logic [AW-1:0] a;
      bit            is_wr;
      bit            hold;
      repeat (3) @(negedge clk);
      checkOutput(tag("rst_CE"), CE, 1);
      checkOutput(tag("rst_WE"), WE, 1);
      checkOutput(tag("rst_OE"), OE, 1);
      checkOutput(tag("rst_IO_z"), {31'd0, IO === {DW{1'bz}}}, 1);
      checkOutput(tag("rst_A"), A, 0);
      checkOutput(tag("rst_rdata"), rsp_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput(tag("ready_after_rst"), req_ready, 1);

      applyStimulus(1'b1, 19'h12345, 8'hA5, 1'b0, 1'b1);
      repeat (W + 2) begin
        checkOutput(tag("ready_busy"), req_ready, 0);
        @(negedge clk);
      end
      checkOutput(tag("ready_return"), req_ready, 1);
      applyStimulus(1'b0, 19'h12345, 8'h00, 1'b0, 1'b1);
      repeat (W + 3) @(negedge clk);

      // Alternating write/read with valid held high the whole time.
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, 19'h00001, 8'h3C, 1'b1, 1'b1);
        applyStimulus(1'b0, 19'h00001, 8'h00, (i != 3), 1'b1);
      end
      repeat (W + 3) @(negedge clk);

      for (int i = 0; i < 30; i++) begin
        is_wr = (written.size() == 0) || ($urandom_range(1, 0) == 1);
        if (is_wr) a = AW'($urandom_range(19'h3FFFF, 0));
        else       a = written[$urandom_range(written.size() - 1, 0)];
        hold = ($urandom_range(2, 0) != 0) && (i != 29);
        applyStimulus(is_wr, a, DW'($urandom), hold, 1'b1);
        if (!hold) repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      repeat (W + 4) @(negedge clk);

      // Reset lands in the middle of a write's ACCESS window.
      applyStimulus(1'b1, 19'h7FFFF, 8'h5A, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput(tag("abort_WE"), WE, 1);
      checkOutput(tag("abort_CE"), CE, 1);
      checkOutput(tag("abort_IO_z"), {31'd0, IO === {DW{1'bz}}}, 1);
      exp_wr.delete();
      exp_rsp.delete();
      prev_hold = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput(tag("ready_after_abort"), req_ready, 1);
      applyStimulus(1'b0, 19'h12345, 8'h00, 1'b0, 1'b1);
      repeat (W + 4) @(negedge clk);
      checkOutput(tag("rsp_drained"), exp_rsp.size(), 0);
      checkOutput(tag("wr_drained"), exp_wr.size(), 0);
      done = 1'b1;
    end
  end

  initial begin : finale
    int t = 0;
    while (!(u[0].done && u[1].done) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!(u[0].done && u[1].done)) checkOutput("global_timeout", 0, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
